register_bank: RTL

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/lapido_defs.sv | 14 +
 rtl/reg_scoreboard.sv | 72 +++++++
 rtl/register_bank.sv | 64 ++++++
 3 files changed

// File: rtl/lapido_defs.sv
// Shared register-file definitions: widths, register count and the hard-wired zero register.
package lapido_defs;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_NREGS  = 32;
    localparam int unsigned REG_AW     = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [1:0]        pend_t;

    localparam reg_addr_t R0       = '0;
    localparam pend_t     PEND_MAX = 2'd3;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-writer counters, decode stall generation and sticky protocol error.
module reg_scoreboard
    import lapido_defs::*;
#(
    parameter int unsigned NREGS = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_dst,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_dst,
    input  logic              flush,
    output logic              stall,
    output logic              sb_err
);

    pend_t pend_q [NREGS];
    pend_t pend_d [NREGS];
    logic  sb_err_q, sb_err_d;
    logic  wb, issue_acc, sat_hit;

    // A single outstanding producer is fine if it writes back this very cycle (bypass).
    function automatic logic src_busy(input logic used, input pend_t p, input logic wb_hit);
        return used && ((p >= 2'd2) || ((p == 2'd1) && !wb_hit));
    endfunction

    always_comb begin
        wb        = wr_en && (wr_dst != R0);
        sat_hit   = issue_en && (issue_dst != R0) && (pend_q[issue_dst] == PEND_MAX);
        stall     = !rst && (src_busy(rs_used && (rs_addr != R0), pend_q[rs_addr],
                                      wb && (wr_dst == rs_addr)) ||
                             src_busy(rt_used && (rt_addr != R0), pend_q[rt_addr],
                                      wb && (wr_dst == rt_addr)) ||
                             sat_hit);
        issue_acc = issue_en && !stall && (issue_dst != R0);

        sb_err_d = sb_err_q;
        if (wb && (pend_q[wr_dst] == 2'd0) && !(issue_acc && (issue_dst == wr_dst))) begin
            sb_err_d = 1'b1;
        end

        pend_d[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            pend_d[i] = pend_q[i];
            if (flush) begin
                pend_d[i] = '0;
            end else if (issue_acc && (issue_dst == reg_addr_t'(i))) begin
                if (!(wb && (wr_dst == reg_addr_t'(i)))) pend_d[i] = pend_q[i] + 2'd1;
            end else if (wb && (wr_dst == reg_addr_t'(i)) && (pend_q[i] != 2'd0)) begin
                pend_d[i] = pend_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: rtl/register_bank.sv
// Architectural register file with write-back bypass on both read ports and a hazard scoreboard.
module register_bank
    import lapido_defs::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NREGS  = DEF_NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_dst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_dst,
    input  logic              flush,
    output logic              stall,
    output logic              sb_err
);

    logic [DATA_W-1:0] regs_q [NREGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else if (wr_en && (wr_dst != R0)) begin
            regs_q[wr_dst] <= wr_data;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (wr_en && (wr_dst == rs_addr)) rs_data = wr_data;
        if (wr_en && (wr_dst == rt_addr)) rt_data = wr_data;
        if (rs_addr == R0) rs_data = '0;
        if (rt_addr == R0) rt_data = '0;
    end

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_dst    (wr_dst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_used   (rs_used),
        .rt_used   (rt_used),
        .issue_en  (issue_en),
        .issue_dst (issue_dst),
        .flush     (flush),
        .stall     (stall),
        .sb_err    (sb_err)
    );

endmodule
